mul_iter_unit: RTL and testbench

- Multi-cycle 32x32 integer multiplier that answers the EX-stage multiply request interface.
- Accepts operands and a signedness flag while EX holds MUL_START. Iterates shift-add, then pulses MUL_READY for exactly one cycle with a 64-bit product.
- Sits beside EX. EX stalls the pipeline until it sees MUL_READY, then takes MUL_RESULT[31:0] in that same cycle.

---
 rtl/mul_iter_unit.sv | 120 ++++++++++++
 tb/tb_mul_iter_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mul_iter_unit.sv
// Iterative 32x32 shift-add multiplier for the EX stage; pulses MUL_READY once per product.
// Optional build macro MUL_RADIX4_EN: retire two multiplier bits per cycle (radix-4).
module mul_iter_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MUL_START,
  input  logic                  MUL_CANCEL,
  input  logic                  SIGNED_MUL,
  input  logic [DATA_W-1:0]     MULTIPLICAND,
  input  logic [DATA_W-1:0]     MULTIPLIER,
  output logic                  MUL_READY,
  output logic [2*DATA_W-1:0]   MUL_RESULT
);

  localparam int PROD_W = 2 * DATA_W;

`ifdef MUL_RADIX4_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W / 2 - 1);
`else
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   abs_a_q, abs_a_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   result_q, result_d;
  logic                ready_q, ready_d;

  logic [DATA_W-1:0]   abs_a_in, abs_b_in;
  logic [PROD_W-1:0]   acc_step;

  // One radix-2 step: conditionally add A into the high half, keep the carry, shift right by one.
  function automatic logic [PROD_W-1:0] step(input logic [PROD_W-1:0] acc,
                                             input logic [DATA_W-1:0] a);
    logic [DATA_W:0] sum;
    sum = {1'b0, acc[PROD_W-1:DATA_W]} + ({1'b0, a} & {(DATA_W+1){acc[0]}});
    return {sum, acc[DATA_W-1:1]};
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    acc_d    = acc_q;
    abs_a_d  = abs_a_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ready_d  = 1'b0;

    // -2^31 negates to itself, which read unsigned is the correct magnitude.
    abs_a_in = (SIGNED_MUL && MULTIPLICAND[DATA_W-1]) ? -MULTIPLICAND : MULTIPLICAND;
    abs_b_in = (SIGNED_MUL && MULTIPLIER[DATA_W-1])   ? -MULTIPLIER   : MULTIPLIER;

`ifdef MUL_RADIX4_EN
    acc_step = step(step(acc_q, abs_a_q), abs_a_q);
`else
    acc_step = step(acc_q, abs_a_q);
`endif

    case (state_q)
      IDLE: begin
        if (MUL_START && !MUL_CANCEL) begin
          abs_a_d = abs_a_in;
          neg_d   = SIGNED_MUL & (MULTIPLICAND[DATA_W-1] ^ MULTIPLIER[DATA_W-1]);
          acc_d   = {{DATA_W{1'b0}}, abs_b_in};
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // A flushed EX (START dropped) is an abort, same as an explicit cancel.
        if (MUL_CANCEL || !MUL_START) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            result_d = neg_q ? -acc_step : acc_step;
            ready_d  = 1'b1;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      abs_a_q  <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q  <= state_d;
      acc_q    <= acc_d;
      abs_a_q  <= abs_a_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign MUL_READY  = ready_q;
  assign MUL_RESULT = result_q;

endmodule

// File: tb/tb_mul_iter_unit.sv
// Directed self-checking bench for mul_iter_unit: products, latency, cancel, withdrawal, reset.
module tb_mul_iter_unit;

`ifdef MUL_RADIX4_EN
  localparam int LAT      = 16;
  localparam int RST_EDGE = 10;
`else
  localparam int LAT      = 32;
  localparam int RST_EDGE = 20;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        MUL_START = 1'b0;
  logic        MUL_CANCEL = 1'b0;
  logic        SIGNED_MUL = 1'b0;
  logic [31:0] MULTIPLICAND = '0;
  logic [31:0] MULTIPLIER = '0;
  logic        MUL_READY;
  logic [63:0] MUL_RESULT;

  int n_checks = 0;
  int n_errors = 0;

  mul_iter_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .MUL_START    (MUL_START),
    .MUL_CANCEL   (MUL_CANCEL),
    .SIGNED_MUL   (SIGNED_MUL),
    .MULTIPLICAND (MULTIPLICAND),
    .MULTIPLIER   (MULTIPLIER),
    .MUL_READY    (MUL_READY),
    .MUL_RESULT   (MUL_RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle at the falling edge where outputs are sampled and inputs driven.
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Full request: accept edge E0, READY must appear after edge E<LAT> and last one cycle.
  task automatic do_mul(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int lat;
    bit seen;
    seen         = 1'b0;
    SIGNED_MUL   = sgn;
    MULTIPLICAND = a;
    MULTIPLIER   = b;
    MUL_CANCEL   = 1'b0;
    MUL_START    = 1'b1;
    cycle();
    lat          = 0;
    MULTIPLICAND = 32'hDEAD_BEEF;
    MULTIPLIER   = 32'h0BAD_F00D;
    SIGNED_MUL   = ~sgn;
    for (int i = 0; i < 100 && !seen; i++) begin
      cycle();
      lat++;
      seen = MUL_READY;
    end
    check({tag, "_ready_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_result"}, MUL_RESULT, exp);
    MUL_START = 1'b0;
    cycle();
    check({tag, "_ready_drop"}, 64'(MUL_READY), 64'd0);
    check({tag, "_result_hold"}, MUL_RESULT, exp);
  endtask

  // Abort mid-CALC at edge edge_n: mode 0 cancel, 1 withdraw START, 2 reset.
  task automatic do_abort(input string tag, input int mode, input int edge_n,
                          input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    bit seen;
    seen         = 1'b0;
    SIGNED_MUL   = 1'b0;
    MULTIPLICAND = a;
    MULTIPLIER   = b;
    MUL_CANCEL   = 1'b0;
    MUL_START    = 1'b1;
    cycle();
    for (int k = 1; k < edge_n; k++) begin
      cycle();
      seen |= MUL_READY;
    end
    case (mode)
      0:       MUL_CANCEL = 1'b1;
      1:       MUL_START  = 1'b0;
      default: begin RST = 1'b0; MUL_START = 1'b0; end
    endcase
    cycle();
    check({tag, "_ready_after_abort"}, 64'(MUL_READY), 64'd0);
    check({tag, "_result_after_abort"}, MUL_RESULT, exp);
    RST        = 1'b1;
    MUL_START  = 1'b0;
    MUL_CANCEL = 1'b0;
    repeat (LAT + 5) begin
      cycle();
      seen |= MUL_READY;
    end
    check({tag, "_no_pulse"}, 64'(seen), 64'd0);
    check({tag, "_result_kept"}, MUL_RESULT, exp);
  endtask

  initial begin
    cycle();
    cycle();
    check("reset_ready", 64'(MUL_READY), 64'd0);
    check("reset_result", MUL_RESULT, 64'd0);
    RST = 1'b1;
    cycle();

    do_mul("u_ffff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    do_mul("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
    do_mul("u_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB);
    do_mul("s_min2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    do_abort("cancel", 0, 10, 32'd5, 32'd6, 64'h4000_0000_0000_0000);

    // CANCEL in IDLE must block accept; an illegal accept here would shorten the next latency.
    SIGNED_MUL   = 1'b0;
    MULTIPLICAND = 32'd5;
    MULTIPLIER   = 32'd6;
    MUL_START    = 1'b1;
    MUL_CANCEL   = 1'b1;
    cycle();
    check("idle_cancel_ready", 64'(MUL_READY), 64'd0);
    do_mul("restart_5x6", 1'b0, 32'd5, 32'd6, 64'd30);

    do_abort("withdraw", 1, 5, 32'd9, 32'd9, 64'd30);
    do_mul("u_2x3", 1'b0, 32'd2, 32'd3, 64'd6);
    do_mul("b2b_zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0);
    do_mul("s_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    do_mul("u_min_x2", 1'b0, 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);

    do_abort("reset_mid", 2, RST_EDGE, 32'h0000_1234, 32'h0000_0010, 64'd0);
    do_mul("s_max_min", 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
